// File: rtl/ddc_chan_out_mux_if.sv
// ddc_chan_out_mux_if: per-channel sample inputs and the tagged I/Q output stream handshake
interface ddc_chan_out_mux_if #(
    parameter int NCH    = 4,
    parameter int DWIDTH = 16,
    parameter int CHW    = 2
);
    logic [NCH*DWIDTH-1:0] din_i;
    logic [NCH*DWIDTH-1:0] din_q;
    logic [NCH-1:0]        din_flag;
    logic                  out_ready;
    logic                  out_valid;
    logic [DWIDTH-1:0]     out_i;
    logic [DWIDTH-1:0]     out_q;
    logic [CHW-1:0]        out_ch;
    modport master (
        output din_i, din_q, din_flag, out_ready,
        input  out_valid, out_i, out_q, out_ch
    );
    modport slave (
        input  din_i, din_q, din_flag, out_ready,
        output out_valid, out_i, out_q, out_ch
    );
endinterface

// File: rtl/ddc_chan_out_mux.sv
// ddc_chan_out_mux: buffers per-channel DDC I/Q results and round-robin muxes them onto one tagged stream
module ddc_chan_out_mux #(
    parameter int NCH    = 4,
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4,
    parameter int CHW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             config_sync,
    input  logic [NCH-1:0]   ch_en_param,
    input  logic             ovf_clr,
    output logic [NCH-1:0]   ovf,
    ddc_chan_out_mux_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [NCH-1:0]    en;
    logic [NCH-1:0]    elig;
    logic [NCH-1:0]    wr;
    logic [NCH-1:0]    pop;
    logic [NCH-1:0]    flush;
    logic [NCH-1:0]    ovf_set;
    logic [AW-1:0]     wr_ptr [NCH];
    logic [AW-1:0]     rd_ptr [NCH];
    logic [CW-1:0]     cnt    [NCH];
    logic [DWIDTH-1:0] mem_i  [NCH][DEPTH];
    logic [DWIDTH-1:0] mem_q  [NCH][DEPTH];
    logic [CHW-1:0]    rr_last;
    logic [CHW-1:0]    grant;
    logic [2*NCH-1:0]  rot;
    logic              found;
    logic              load;

    // Round-robin grant: rotate eligibility so the search starts just after rr_last
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            elig[k] = en[k] && (cnt[k] != '0);
        end
        rot = {elig, elig} >> (int'(rr_last) + 1);
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < NCH; j++) begin
            if (!found && rot[j]) begin
                grant = CHW'((int'(rr_last) + 1 + j) % NCH);
                found = 1'b1;
            end
        end
        load = (!bus.out_valid || bus.out_ready) && found;
    end

    // Per-channel write, pop, flush and overflow decisions (writes use the pre-update mask)
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            pop[k]     = load && (int'(grant) == k);
            flush[k]   = config_sync && en[k] && !ch_en_param[k];
            wr[k]      = en[k] && bus.din_flag[k] && (cnt[k] != FULL || pop[k]);
            ovf_set[k] = en[k] && bus.din_flag[k] && cnt[k] == FULL && !pop[k];
        end
    end

    // FIFO storage; contents need no reset since validity is tracked by the counts
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (wr[k]) begin
                mem_i[k][wr_ptr[k]] <= bus.din_i[k*DWIDTH +: DWIDTH];
                mem_q[k][wr_ptr[k]] <= bus.din_q[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // FIFO pointers and counts, enable mask and sticky overflow flags (set beats clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en  <= '1;
            ovf <= '0;
            for (int k = 0; k < NCH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            en  <= config_sync ? ch_en_param : en;
            ovf <= ovf_set | (ovf & {NCH{!ovf_clr}});
            for (int k = 0; k < NCH; k++) begin
                wr_ptr[k] <= flush[k] ? '0 : wr_ptr[k] + AW'(wr[k]);
                rd_ptr[k] <= flush[k] ? '0 : rd_ptr[k] + AW'(pop[k]);
                cnt[k]    <= flush[k] ? '0 : cnt[k] + CW'(wr[k]) - CW'(pop[k]);
            end
        end
    end

    // Output register: load the granted head, or drop valid once consumed with nothing pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_i     <= '0;
            bus.out_q     <= '0;
            bus.out_ch    <= '0;
            rr_last       <= CHW'(NCH - 1);
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_i     <= mem_i[grant][rd_ptr[grant]];
            bus.out_q     <= mem_q[grant][rd_ptr[grant]];
            bus.out_ch    <= grant;
            rr_last       <= grant;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ddc_chan_out_mux.sv
// tb_ddc_chan_out_mux: randomized self-checking bench with a queue-based reference model
module tb_ddc_chan_out_mux;
    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CHW   = 2;
    localparam int SW    = 1 + CHW + 2*DW + NCH;
    localparam int OW    = CHW + 2*DW;

    logic           clk         = 1'b0;
    logic           rst         = 1'b0;
    logic           config_sync = 1'b0;
    logic           ovf_clr     = 1'b0;
    logic [NCH-1:0] ch_en_param = '1;
    logic [NCH-1:0] ovf;
    int             n_checks    = 0;
    int             n_fails     = 0;

    ddc_chan_out_mux_if #(.NCH(NCH), .DWIDTH(DW), .CHW(CHW)) bus();

    ddc_chan_out_mux #(.NCH(NCH), .DWIDTH(DW), .DEPTH(DEPTH), .CHW(CHW)) dut (
        .clk(clk),
        .rst(rst),
        .config_sync(config_sync),
        .ch_en_param(ch_en_param),
        .ovf_clr(ovf_clr),
        .ovf(ovf),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [2*DW-1:0] fq [NCH][$];
    logic [NCH-1:0]  m_en;
    logic [NCH-1:0]  m_ovf;
    logic            m_valid;
    logic [DW-1:0]   m_i;
    logic [DW-1:0]   m_q;
    logic [CHW-1:0]  m_ch;
    int              m_rr;
    logic [DW-1:0]   si [NCH];
    logic [DW-1:0]   sq [NCH];
    logic [OW-1:0]   got [$];

    function automatic logic [SW-1:0] dut_snap();
        return {bus.out_valid, bus.out_ch, bus.out_i, bus.out_q, ovf};
    endfunction

    function automatic logic [SW-1:0] mod_snap();
        return {m_valid, m_ch, m_i, m_q, m_ovf};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) fq[k].delete();
        m_en = '1;
        m_ovf = '0;
        m_valid = 1'b0;
        m_i = '0;
        m_q = '0;
        m_ch = '0;
        m_rr = NCH - 1;
    endtask

    // Apply the next clock edge's effect to the model from the inputs currently driven
    task automatic model_edge();
        int g;
        logic [2*DW-1:0] h;
        g = -1;
        if (!m_valid || bus.out_ready) begin
            for (int j = 1; j <= NCH; j++) begin
                int k;
                k = (m_rr + j) % NCH;
                if (g < 0 && m_en[k] && fq[k].size() > 0) g = k;
            end
        end
        if (g >= 0) begin
            h = fq[g].pop_front();
            m_i = h[2*DW-1:DW];
            m_q = h[DW-1:0];
            m_ch = CHW'(g);
            m_rr = g;
            m_valid = 1'b1;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        if (ovf_clr) m_ovf = '0;
        for (int k = 0; k < NCH; k++) begin
            if (m_en[k] && bus.din_flag[k]) begin
                if (fq[k].size() < DEPTH) fq[k].push_back({bus.din_i[k*DW +: DW], bus.din_q[k*DW +: DW]});
                else m_ovf[k] = 1'b1;
            end
        end
        if (config_sync) begin
            for (int k = 0; k < NCH; k++) if (m_en[k] && !ch_en_param[k]) fq[k].delete();
            m_en = ch_en_param;
        end
    endtask

    task automatic cyc(input logic [NCH-1:0] flag, input bit keep);
        for (int k = 0; k < NCH; k++) begin
            if (!keep) begin
                si[k] = DW'($urandom);
                sq[k] = DW'($urandom);
            end
            bus.din_i[k*DW +: DW] = si[k];
            bus.din_q[k*DW +: DW] = sq[k];
        end
        bus.din_flag = flag;
        model_edge();
        @(negedge clk);
        bus.din_flag = '0;
        config_sync = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic drain(input int n);
        got.delete();
        bus.out_ready = 1'b1;
        repeat (n) begin
            if (bus.out_valid) got.push_back({bus.out_ch, bus.out_i, bus.out_q});
            cyc('0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_i !== '0 || bus.out_q !== '0) begin n_fails++; $display("FAIL reset_data: got %h/%h want 0/0", bus.out_i, bus.out_q); end
        n_checks++; if (bus.out_ch !== '0) begin n_fails++; $display("FAIL reset_ch: got %0d want 0", bus.out_ch); end
        n_checks++; if (ovf !== '0) begin n_fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        si[0] = 16'h1234;
        sq[0] = 16'hABCD;
        for (int k = 1; k < NCH; k++) begin
            si[k] = '0;
            sq[k] = '0;
        end
        cyc(4'b0001, 1'b1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL single_write_edge: valid %b want 0", bus.out_valid); end
        cyc('0, 1'b0);
        n_checks++; if ({bus.out_valid, bus.out_ch, bus.out_i, bus.out_q} !== {1'b1, 2'd0, 16'h1234, 16'hABCD}) begin
            n_fails++; $display("FAIL single_out: got v=%b ch=%0d i=%h q=%h want v=1 ch=0 i=1234 q=abcd", bus.out_valid, bus.out_ch, bus.out_i, bus.out_q);
        end
        cyc('0, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL single_fall: valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [2*DW-1:0] exp_q [NCH][$];
        logic [2*DW-1:0] e;
        do_reset();
        bus.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) got.push_back({bus.out_ch, bus.out_i, bus.out_q});
            cyc(c < 3 ? '1 : '0, 1'b0);
            if (c < 3) for (int k = 0; k < NCH; k++) exp_q[k].push_back({si[k], sq[k]});
            n_checks++; if (dut_snap() !== mod_snap()) begin n_fails++; $display("FAIL rr_model cycle %0d: got %h want %h", c, dut_snap(), mod_snap()); end
        end
        n_checks++; if (got.size() != 12) begin n_fails++; $display("FAIL rr_count: got %0d want 12", got.size()); end
        for (int n = 0; n < got.size() && n < 12; n++) begin
            e = exp_q[n % NCH].pop_front();
            n_checks++; if (got[n] !== {CHW'(n % NCH), e}) begin n_fails++; $display("FAIL rr_order %0d: got %h want %h", n, got[n], {CHW'(n % NCH), e}); end
        end
        n_checks++; if (ovf !== '0) begin n_fails++; $display("FAIL rr_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        logic [2*DW-1:0] sent [$];
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cyc(4'b0100, 1'b0);
            sent.push_back({si[2], sq[2]});
        end
        n_checks++; if (ovf !== 4'b0100) begin n_fails++; $display("FAIL ovf_set: got %b want 0100", ovf); end
        n_checks++; if ({bus.out_valid, bus.out_ch, bus.out_i, bus.out_q} !== {1'b1, 2'd2, sent[0]}) begin
            n_fails++; $display("FAIL ovf_hold: got v=%b ch=%0d %h%h want v=1 ch=2 %h", bus.out_valid, bus.out_ch, bus.out_i, bus.out_q, sent[0]);
        end
        drain(8);
        n_checks++; if (got.size() != 5) begin n_fails++; $display("FAIL ovf_count: got %0d want 5", got.size()); end
        for (int n = 0; n < got.size() && n < 5; n++) begin
            n_checks++; if (got[n] !== {2'd2, sent[n]}) begin n_fails++; $display("FAIL ovf_data %0d: got %h want %h", n, got[n], {2'd2, sent[n]}); end
        end
        n_checks++; if (ovf !== 4'b0100) begin n_fails++; $display("FAIL ovf_sticky: got %b want 0100", ovf); end
        ovf_clr = 1'b1;
        cyc('0, 1'b0);
        n_checks++; if (ovf !== '0) begin n_fails++; $display("FAIL ovf_clr: got %b want 0", ovf); end
    endtask

    task automatic test_disable();
        logic [2*DW-1:0] s1, d0, d3;
        do_reset();
        cyc(4'b0010, 1'b0);
        s1 = {si[1], sq[1]};
        repeat (4) cyc(4'b0010, 1'b0);
        cyc(4'b1001, 1'b0);
        d0 = {si[0], sq[0]};
        d3 = {si[3], sq[3]};
        config_sync = 1'b1;
        ch_en_param = 4'b1101;
        cyc('0, 1'b0);
        repeat (3) cyc(4'b0010, 1'b0);
        n_checks++; if (ovf !== '0) begin n_fails++; $display("FAIL dis_ovf: got %b want 0", ovf); end
        n_checks++; if (dut_snap() !== mod_snap()) begin n_fails++; $display("FAIL dis_model: got %h want %h", dut_snap(), mod_snap()); end
        drain(8);
        n_checks++; if (got.size() != 3) begin n_fails++; $display("FAIL dis_count: got %0d want 3", got.size()); end
        if (got.size() == 3) begin
            n_checks++; if (got[0] !== {2'd1, s1} || got[1] !== {2'd3, d3} || got[2] !== {2'd0, d0}) begin
                n_fails++; $display("FAIL dis_seq: got %h %h %h want %h %h %h", got[0], got[1], got[2], {2'd1, s1}, {2'd3, d3}, {2'd0, d0});
            end
        end
        config_sync = 1'b1;
        ch_en_param = '1;
        cyc('0, 1'b0);
        cyc(4'b0010, 1'b0);
        s1 = {si[1], sq[1]};
        drain(4);
        n_checks++; if (got.size() != 1 || got[0] !== {2'd1, s1}) begin
            n_fails++; $display("FAIL reenable: got %0d items first %h want 1 item %h", got.size(), got.size() ? got[0] : '0, {2'd1, s1});
        end
    endtask

    task automatic test_full_pop();
        logic [2*DW-1:0] sent [$];
        do_reset();
        for (int c = 0; c < 5; c++) begin
            cyc(4'b0001, 1'b0);
            sent.push_back({si[0], sq[0]});
        end
        bus.out_ready = 1'b1;
        cyc(4'b0001, 1'b0);
        sent.push_back({si[0], sq[0]});
        n_checks++; if (ovf !== '0) begin n_fails++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
        bus.out_ready = 1'b0;
        cyc(4'b0001, 1'b0);
        n_checks++; if (ovf !== 4'b0001) begin n_fails++; $display("FAIL fullpop_still_full: got %b want 0001", ovf); end
        drain(8);
        n_checks++; if (got.size() != 5) begin n_fails++; $display("FAIL fullpop_count: got %0d want 5", got.size()); end
        for (int n = 0; n < got.size() && n < 5; n++) begin
            n_checks++; if (got[n] !== {2'd0, sent[n+1]}) begin n_fails++; $display("FAIL fullpop_data %0d: got %h want %h", n, got[n], {2'd0, sent[n+1]}); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            bus.out_ready = ($urandom_range(3) != 0);
            config_sync = ($urandom_range(31) == 0);
            ch_en_param = NCH'($urandom) | NCH'($urandom);
            ovf_clr = ($urandom_range(15) == 0);
            cyc(NCH'($urandom), 1'b0);
            n_checks++; if (dut_snap() !== mod_snap()) begin n_fails++; $display("FAIL random cycle %0d: got %h want %h", c, dut_snap(), mod_snap()); end
        end
        config_sync = 1'b1;
        ch_en_param = '1;
        cyc('0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) cyc(4'b1000, 1'b0);
        n_checks++; if ({bus.out_valid, bus.out_ch, ovf} !== {1'b1, 2'd3, 4'b1000}) begin
            n_fails++; $display("FAIL midrst_pre: got v=%b ch=%0d ovf=%b want v=1 ch=3 ovf=1000", bus.out_valid, bus.out_ch, ovf);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.out_valid, bus.out_ch, ovf} !== '0) begin
            n_fails++; $display("FAIL midrst_async: got v=%b ch=%0d ovf=%b want all 0", bus.out_valid, bus.out_ch, ovf);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc('0, 1'b0);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL midrst_stale cycle %0d: valid %b want 0", c, bus.out_valid); end
        end
    endtask

    initial begin
        bus.din_i = '0;
        bus.din_q = '0;
        bus.din_flag = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_disable();
        test_full_pop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
